sobel_window: RTL and testbench
===============================

# sobel_window

Streaming 3x3 window generator that sits directly upstream of the Sobel operator stage. It accepts 8-bit grayscale pixels in raster order, one per handshake. Two line buffers hold the previous rows, and the block emits one packed 72-bit 3x3 neighbourhood per valid interior pixel, in the bit layout the Sobel stage consumes. Border pixels get no padding: a frame of W x H pixels yields (W-2) x (H-2) windows.

## Interface
- `IMG_WIDTH`, 720: pixels per row; at least 3.
- `IMG_HEIGHT`, 540: rows per frame; at least 3.
- `DWIDTH_IN`, 8: pixel width.
- `DWIDTH_OUT`, 72: window width, 9 x `DWIDTH_IN`.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_data` input 8: pixel, raster order.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a pixel this cycle.
- `out_window` output 72: packed 3x3 window.
- `out_valid` output 1: `out_window` is valid.
- `out_ready` input 1: downstream accepts the window.
- `out_last` output 1: marks the final window of the frame; qualified by `out_valid`.

## Operation
- Accept: a pixel is accepted when `in_valid && in_ready`. Nothing advances without an accept.
- Position counters: `col` in 0..W-1 and `row` in 0..H-1, each `$clog2` sized, both reset to 0.
  - On accept, `col` increments.
  - At W-1, `col` wraps to 0 and `row` increments.
  - At (H-1, W-1), both wrap to 0 and the next pixel starts a new frame.
- Line buffers: two buffers, `lb0` holding row-1 and `lb1` holding row-2, each W x 8, addressed by `col`.
  - On accept at column c, both are read at c (read-before-write).
  - Then `lb1[c] <= lb0[c]` and `lb0[c] <= in_data`.
- Window register: 3 columns x 3 rows.
  - On accept, columns shift left: column 0 takes column 1, column 1 takes column 2.
  - Column 2 is loaded with {row 0 = `lb1[c]`, row 1 = `lb0[c]`, row 2 = `in_data`}.
- Packing: slot s = col_idx*3 + row_idx, with row_idx 0 the top (oldest) row and col_idx 0 the left (oldest) column. Slot s occupies `out_window[s*8 +: 8]`, so slot 4 is the centre pixel.
- Emit condition: on an accept at position (row, col) with row >= 2 and col >= 2 (pre-increment values), the shifted window is registered to `out_window` and `out_valid` is set. `out_last` = (row == H-1 && col == W-1).
- Non-emitting accepts: accepts at col < 2 update internal state only. At those positions the window still holds the previous row's tail, and that data is never emitted.
- Stale data on a new frame: line-buffer contents from the previous frame are not cleared. They are never emitted because output is gated on row >= 2.
- Output register is one entry, skid-free:
  - `in_ready = !out_valid || out_ready`.
  - `out_valid` clears when `out_ready` is high and there is no new emitting accept.
  - On `out_ready` together with an emitting accept, the register reloads and `out_valid` stays 1.
- Reset (asynchronous, low):
  - `out_valid`, `out_last` and `out_window` go to 0.
  - `row` and `col` go to 0.
  - The window register goes to 0.
  - Line-buffer contents are don't-care.
  - A reset mid-frame discards the partial frame, and the next accepted pixel is (0,0).

## Timing
- Latency: a window appears on `out_window`/`out_valid` in the cycle after its final pixel is accepted.
- Throughput: one pixel per cycle sustained while `out_ready` is high.
- Backpressure:
  - While `out_valid && !out_ready`, `in_ready` is 0.
  - `out_window` and `out_last` hold stable.
  - No pixel is accepted.
- `in_ready` depends combinationally only on `out_valid` and `out_ready`. It has no path from `in_valid`.
- Line-buffer read is combinational from `col`. Read and write complete in the same accept cycle.
- Between frames there is no bubble: pixel (0,0) of frame N+1 may be accepted in the cycle after pixel (H-1, W-1) of frame N.

## Structure
- Shared package `sobel_pkg` holds:
  - `PIXEL_W = 8` and `WIN_SIZE = 9`.
  - The slot-index function `slot(c, r) = c*3 + r`, shared with the Sobel operator so the packing is defined once.
- Sub-module `line_buffer`: parameterised depth, 8-bit, one combinational read port and one synchronous write port at the same address, with write enable. It is instantiated twice.

## Test plan
- 5x4 frame, pixel value = 10*row + col, `out_ready` held 1:
  - Exactly 6 windows.
  - First window slots 0..8 = 0, 10, 20, 1, 11, 21, 2, 12, 22.
  - Last window slots = 12, 22, 32, 13, 23, 33, 14, 24, 34, with `out_last` = 1 on that window only.
- Same frame with `out_ready` toggling 1-0-0-1 each cycle:
  - Identical window sequence.
  - `out_window` stable while stalled.
  - `in_ready` = 0 exactly when `out_valid && !out_ready`.
- Two back-to-back 5x4 frames, the second with pixel value = 100 + 10*row + col:
  - The second frame's first window is 100, 110, 120, 101, 111, 121, 102, 112, 122.
  - No window is emitted during the second frame's rows 0-1.
- `in_valid` gaps (random 50% duty) on the 5x4 frame: windows are unchanged from the first scenario and the count is 6.
- Reset asserted after 8 pixels, then a fresh 5x4 frame:
  - `out_valid` goes to 0 immediately while reset is low.
  - The fresh frame produces the same 6 windows as the first scenario.
- Minimum 3x3 frame: exactly one window, slots = 0, 10, 20, 1, 11, 21, 2, 12, 22, with `out_last` = 1.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel datapath: pixel width, window geometry
// and the slot index that fixes how a 3x3 window packs into a flat bus.
package sobel_pkg;

    localparam int unsigned PIXEL_W   = 8;
    localparam int unsigned WIN_DIM   = 3;
    localparam int unsigned WIN_SIZE  = 9;
    localparam int unsigned WIN_BITS  = WIN_SIZE * PIXEL_W;
    localparam int unsigned WIN_IDX_W = $clog2(WIN_BITS);

    typedef logic [PIXEL_W-1:0] pixel_t;

    // One window column; element 0 is the top (oldest) row.
    typedef logic [WIN_DIM-1:0][PIXEL_W-1:0] win_col_t;

    // Flat slot of column c, row r; column 0 and row 0 are the oldest.
    function automatic int unsigned slot(input int unsigned c, input int unsigned r);
        return c * WIN_DIM + r;
    endfunction

endpackage

// File: rtl/sobel_window_line_buffer.sv
// Single row store: combinational read and synchronous write at the same
// address, so an accept reads the old value and overwrites it in one cycle.
// Ports: clock, wr_en, addr, wr_data, rd_data_c (combinational read).
module line_buffer #(
    parameter int unsigned DEPTH = 720,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data_c = mem[addr];

    // Contents need no reset; stale rows are never emitted.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window.sv
// Streaming 3x3 window generator for the Sobel stage. Takes raster-order
// pixels, keeps two previous rows in line buffers and emits one packed
// window per interior pixel ((W-2) x (H-2) windows per frame).
// Ports:
//   clock, reset (async, active low)
//   in_data/in_valid/in_ready     pixel input handshake
//   out_window/out_valid/out_ready/out_last  window output handshake
module sobel_window
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned DWIDTH_IN  = 8,
    parameter int unsigned DWIDTH_OUT = 72
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DWIDTH_IN-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DWIDTH_OUT-1:0] out_window,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    win_col_t [WIN_DIM-1:0] win_q;
    win_col_t [WIN_DIM-1:0] win_next_c;
    logic [WIN_BITS-1:0]    packed_c;

    pixel_t pix_in_c;
    pixel_t lb0_rd_c;
    pixel_t lb1_rd_c;

    logic accept_c;
    logic emit_c;
    logic col_last_c;
    logic row_last_c;

    // Single-entry output register: accept only when it is free or draining.
    assign in_ready   = !out_valid || out_ready;
    assign accept_c   = in_valid && in_ready;
    assign pix_in_c   = pixel_t'(in_data);
    assign col_last_c = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last_c = (row_q == ROW_W'(IMG_HEIGHT - 1));

    // Only positions with two rows above and two columns left form a window.
    assign emit_c = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // lb0 holds row-1, lb1 holds row-2; both shift down on every accept.
    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_W)
    ) u_lb0 (
        .clock     (clock),
        .wr_en     (accept_c),
        .addr      (col_q),
        .wr_data   (pix_in_c),
        .rd_data_c (lb0_rd_c)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIXEL_W)
    ) u_lb1 (
        .clock     (clock),
        .wr_en     (accept_c),
        .addr      (col_q),
        .wr_data   (lb0_rd_c),
        .rd_data_c (lb1_rd_c)
    );

    // Shifted window and its flat packing for the Sobel stage.
    always_comb begin
        win_next_c    = win_q;
        packed_c      = '0;
        win_next_c[0] = win_q[1];
        win_next_c[1] = win_q[2];
        win_next_c[2] = {pix_in_c, lb0_rd_c, lb1_rd_c};
        for (int unsigned c = 0; c < WIN_DIM; c++) begin
            for (int unsigned r = 0; r < WIN_DIM; r++) begin
                packed_c[WIN_IDX_W'(slot(c, r) * PIXEL_W) +: PIXEL_W] = win_next_c[2'(c)][2'(r)];
            end
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept_c) begin
            if (col_last_c) begin
                col_q <= '0;
                row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Window shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_q <= '0;
        end else if (accept_c) begin
            win_q <= win_next_c;
        end
    end

    // Output register; reloads on an emitting accept even while draining.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else if (emit_c) begin
            out_valid  <= 1'b1;
            out_last   <= row_last_c && col_last_c;
            out_window <= DWIDTH_OUT'(packed_c);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] out_window;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [7:0]  m_in_data;
    logic        m_in_valid;
    logic        m_in_ready;
    logic [71:0] m_out_window;
    logic        m_out_valid;
    logic        m_out_ready;
    logic        m_out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pix_q[$];
    logic [71:0] got_w[$];
    logic [71:0] exp_w[$];
    bit          got_l[$];
    bit          exp_l[$];

    sobel_window #(
        .IMG_WIDTH(5), .IMG_HEIGHT(4), .DWIDTH_IN(8), .DWIDTH_OUT(72)
    ) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_window(out_window), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    sobel_window #(
        .IMG_WIDTH(3), .IMG_HEIGHT(3), .DWIDTH_IN(8), .DWIDTH_OUT(72)
    ) dut_min (
        .clock(clock), .reset(reset),
        .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .out_window(m_out_window), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out_last(m_out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'(base + 10 * r + c);
    endfunction

    function automatic void push_frame(input int w, input int h, input int base);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix_q.push_back(pix(base, r, c));
    endfunction

    // Reference: every interior pixel (r,c) yields the 3x3 neighbourhood
    // ending at it, slot = col_idx*3 + row_idx, oldest row/column first.
    function automatic void expect_frame(input int w, input int h, input int base);
        logic [71:0] win;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                win = '0;
                for (int ci = 0; ci < 3; ci++)
                    for (int ri = 0; ri < 3; ri++)
                        win[7'((ci * 3 + ri) * 8) +: 8] = pix(base, r - 2 + ri, c - 2 + ci);
                exp_w.push_back(win);
                exp_l.push_back(r == h - 1 && c == w - 1);
            end
        end
    endfunction

    function automatic void clear_all();
        pix_q.delete(); got_w.delete(); exp_w.delete(); got_l.delete(); exp_l.delete();
    endfunction

    task automatic compare_results(input string tag);
        chk({tag, "_count"}, 72'(got_w.size()), 72'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++) begin
            if (i < got_w.size()) begin
                chk($sformatf("%s_win%0d", tag, i), got_w[i], exp_w[i]);
                chk($sformatf("%s_last%0d", tag, i), 72'(got_l[i]), 72'(exp_l[i]));
            end
        end
    endtask

    // Feeds pix_q to the 5x4 DUT; entered and left at posedge+1.
    // rdy_mode 1 toggles out_ready 1-0-0-1; gap_mode 1 randomises in_valid.
    task automatic drive_stream(input int rdy_mode, input int gap_mode, input bit drain);
        int          idx = 0;
        int          cyc = 0;
        bit          stalled_prev = 0;
        logic [71:0] held = '0;
        while ((idx < pix_q.size() || (drain && out_valid)) && cyc < 2000) begin
            in_valid  = (idx < pix_q.size()) && (gap_mode == 0 || $urandom_range(0, 1) == 1);
            in_data   = in_valid ? pix_q[idx] : 8'($urandom);
            out_ready = (rdy_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clock);
            chk("in_ready_rule", 72'(in_ready), 72'(!(out_valid && !out_ready)));
            if (stalled_prev) chk("stall_hold", out_window, held);
            stalled_prev = out_valid && !out_ready;
            held = out_window;
            if (out_valid && out_ready) begin
                got_w.push_back(out_window);
                got_l.push_back(out_last);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("stream_accepted", 72'(idx), 72'(pix_q.size()));
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    localparam logic [71:0] FIRST_WIN  = 72'h16_0C_02_15_0B_01_14_0A_00;
    localparam logic [71:0] LAST_WIN   = 72'h22_18_0E_21_17_0D_20_16_0C;
    localparam logic [71:0] FIRST_WIN2 = 72'h7A_70_66_79_6F_65_78_6E_64;

    initial begin
        int idx;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'(0));
        chk("rst_out_last", 72'(out_last), 72'(0));
        chk("rst_out_window", out_window, 72'(0));
        chk("rst_in_ready", 72'(in_ready), 72'(1));
        pulse_reset();

        // Basic frame, always ready
        clear_all(); push_frame(5, 4, 0); expect_frame(5, 4, 0);
        drive_stream(0, 0, 1);
        compare_results("s1");
        if (got_w.size() == 6) begin
            chk("s1_first_const", got_w[0], FIRST_WIN);
            chk("s1_last_const", got_w[5], LAST_WIN);
        end

        // Toggling backpressure
        clear_all(); push_frame(5, 4, 0); expect_frame(5, 4, 0);
        drive_stream(1, 0, 1);
        compare_results("s2");

        // Two frames back to back
        clear_all(); push_frame(5, 4, 0); push_frame(5, 4, 100);
        expect_frame(5, 4, 0); expect_frame(5, 4, 100);
        drive_stream(0, 0, 1);
        compare_results("s3");
        if (got_w.size() > 6) chk("s3_frame2_first", got_w[6], FIRST_WIN2);

        // Random input gaps
        clear_all(); push_frame(5, 4, 0); expect_frame(5, 4, 0);
        drive_stream(0, 1, 1);
        compare_results("s4");

        // Reset after 8 pixels
        clear_all(); push_frame(5, 4, 0);
        while (pix_q.size() > 8) void'(pix_q.pop_back());
        drive_stream(0, 0, 0);
        reset = 1'b0;
        #1;
        chk("s5_rst_valid", 72'(out_valid), 72'(0));
        pulse_reset();

        // Reset while a window is held under backpressure
        clear_all(); push_frame(5, 4, 0);
        while (pix_q.size() > 13) void'(pix_q.pop_back());
        drive_stream(0, 0, 0);
        out_ready = 1'b0;
        #1;
        chk("s5_held_valid", 72'(out_valid), 72'(1));
        chk("s5_held_window", out_window, FIRST_WIN);
        chk("s5_held_in_ready", 72'(in_ready), 72'(0));
        reset = 1'b0;
        #1;
        chk("s5_rst2_valid", 72'(out_valid), 72'(0));
        chk("s5_rst2_window", out_window, 72'(0));
        chk("s5_rst2_last", 72'(out_last), 72'(0));
        out_ready = 1'b1;
        pulse_reset();

        // Fresh frame after the resets
        clear_all(); push_frame(5, 4, 0); expect_frame(5, 4, 0);
        drive_stream(0, 0, 1);
        compare_results("s5");

        // Minimum 3x3 frame on the second instance
        clear_all(); push_frame(3, 3, 0); expect_frame(3, 3, 0);
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            m_in_valid = (idx < pix_q.size());
            m_in_data  = m_in_valid ? pix_q[idx] : 8'h00;
            @(negedge clock);
            if (m_out_valid && m_out_ready) begin
                got_w.push_back(m_out_window);
                got_l.push_back(m_out_last);
            end
            if (m_in_valid && m_in_ready) idx++;
            @(posedge clock);
            #1;
        end
        m_in_valid = 1'b0;
        compare_results("s6");
        if (got_w.size() == 1) begin
            chk("s6_const", got_w[0], FIRST_WIN);
            chk("s6_last", 72'(got_l[0]), 72'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
